// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage core: turns hazard, redirect, memory
// handshake and halt requests into per-stage enables/flushes, plus perf counters.
module pipeline_ctrl #(
  parameter int CNT_WIDTH    = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_use_stall_i,
  input  logic                 redirect_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_ack_i,
  input  logic                 imem_valid_i,
  input  logic                 halt_i,
  output logic                 pc_en_o,
  output logic                 if_id_en_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_en_o,
  output logic                 id_ex_flush_o,
  output logic                 ex_mem_en_o,
  output logic                 mem_wb_en_o,
  output logic                 halted_o,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  state_e                 state_r;
  state_e                 next_state_s;
  logic [DW-1:0]          drain_cnt_r;
  logic [CNT_WIDTH-1:0]   stall_cnt_r;
  logic [CNT_WIDTH-1:0]   flush_cnt_r;

  logic mem_stall_s;
  logic apply_rules_s;
  logic drain_load_s;
  logic drain_dec_s;
  logic flush_inc_s;
  logic stall_inc_s;
  logic halted_s;
  logic pc_en_s, if_id_en_s, if_id_flush_s, id_ex_en_s, id_ex_flush_s, ex_mem_en_s, mem_wb_en_s;

  assign mem_stall_s = dmem_req_i & ~dmem_ack_i;

  // Next-state and per-stage control decode from current state and hazard inputs
  always_comb begin
    pc_en_s       = 1'b1;
    if_id_en_s    = 1'b1;
    if_id_flush_s = 1'b0;
    id_ex_en_s    = 1'b1;
    id_ex_flush_s = 1'b0;
    ex_mem_en_s   = 1'b1;
    mem_wb_en_s   = 1'b1;
    halted_s      = 1'b0;
    next_state_s  = state_r;
    apply_rules_s = 1'b0;
    drain_load_s  = 1'b0;
    drain_dec_s   = 1'b0;
    flush_inc_s   = 1'b0;

    case (state_r)
      ST_RUN: begin
        if (mem_stall_s) begin
          {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s} = 5'b00000;
          next_state_s = ST_MEM_WAIT;
        end else begin
          apply_rules_s = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ack_i) begin
          {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s} = 5'b00000;
        end else begin
          apply_rules_s = 1'b1;
          next_state_s  = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (mem_stall_s) begin
          {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s} = 5'b00000;
        end else begin
          pc_en_s       = 1'b0;
          if_id_flush_s = 1'b1;
          id_ex_flush_s = 1'b1;
          if (drain_cnt_r == {DW{1'b0}}) begin
            next_state_s = ST_HALTED;
          end else begin
            drain_dec_s = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s} = 5'b00000;
        halted_s = 1'b1;
      end
      default: begin
        {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s} = 5'b00000;
        next_state_s = ST_RUN;
      end
    endcase

    // A redirect makes the load-use and halt requests wrong-path, so it ranks first
    if (apply_rules_s) begin
      if (redirect_i) begin
        if_id_flush_s = 1'b1;
        id_ex_flush_s = 1'b1;
        flush_inc_s   = 1'b1;
      end else if (load_use_stall_i) begin
        pc_en_s       = 1'b0;
        if_id_en_s    = 1'b0;
        id_ex_flush_s = 1'b1;
      end else if (halt_i) begin
        pc_en_s       = 1'b0;
        if_id_flush_s = 1'b1;
        next_state_s  = ST_DRAIN;
        drain_load_s  = 1'b1;
      end else if (!imem_valid_i) begin
        pc_en_s       = 1'b0;
        if_id_flush_s = 1'b1;
      end else begin
        pc_en_s       = 1'b1;
      end
    end else begin
      drain_load_s = drain_load_s;
    end
  end

  assign stall_inc_s = ((state_r == ST_RUN) || (state_r == ST_MEM_WAIT)) && !pc_en_s;

  // FSM state, drain countdown and saturating perf counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_RUN;
      drain_cnt_r <= {DW{1'b0}};
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
      flush_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (drain_load_s) begin
        drain_cnt_r <= DW'(DRAIN_CYCLES - 1);
      end else if (drain_dec_s) begin
        drain_cnt_r <= drain_cnt_r - {{(DW-1){1'b0}}, 1'b1};
      end
      if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  // Controls are forced quiet while reset is asserted
  assign pc_en_o       = rst_ni & pc_en_s;
  assign if_id_en_o    = rst_ni & if_id_en_s;
  assign if_id_flush_o = rst_ni & if_id_flush_s;
  assign id_ex_en_o    = rst_ni & id_ex_en_s;
  assign id_ex_flush_o = rst_ni & id_ex_flush_s;
  assign ex_mem_en_o   = rst_ni & ex_mem_en_s;
  assign mem_wb_en_o   = rst_ni & mem_wb_en_s;
  assign halted_o      = rst_ni & halted_s;
  assign state_o       = state_r;
  assign stall_cnt_o   = stall_cnt_r;
  assign flush_cnt_o   = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios then randomized traffic,
// expectations from an action-table reference model; a narrow-counter twin checks saturation.
module tb_pipeline_ctrl;

  localparam int DRAIN = 3;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic ld = 1'b0, rd = 1'b0, req = 1'b0, ack = 1'b0, iv = 1'b1, hl = 1'b0;

  logic pc_a, ifen_a, iffl_a, idexen_a, idexfl_a, exm_a, mwb_a, halted_a;
  logic [1:0] st_a;
  logic [31:0] sc_a, fc_a;
  logic pc_b, ifen_b, iffl_b, idexen_b, idexfl_b, exm_b, mwb_b, halted_b;
  logic [1:0] st_b;
  logic [3:0] sc_b, fc_b;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_WIDTH(32), .DRAIN_CYCLES(DRAIN)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .load_use_stall_i(ld), .redirect_i(rd),
    .dmem_req_i(req), .dmem_ack_i(ack), .imem_valid_i(iv), .halt_i(hl),
    .pc_en_o(pc_a), .if_id_en_o(ifen_a), .if_id_flush_o(iffl_a), .id_ex_en_o(idexen_a),
    .id_ex_flush_o(idexfl_a), .ex_mem_en_o(exm_a), .mem_wb_en_o(mwb_a), .halted_o(halted_a),
    .state_o(st_a), .stall_cnt_o(sc_a), .flush_cnt_o(fc_a));

  pipeline_ctrl #(.CNT_WIDTH(4), .DRAIN_CYCLES(DRAIN)) dut4 (
    .clk_i(clk), .rst_ni(rst_ni), .load_use_stall_i(ld), .redirect_i(rd),
    .dmem_req_i(req), .dmem_ack_i(ack), .imem_valid_i(iv), .halt_i(hl),
    .pc_en_o(pc_b), .if_id_en_o(ifen_b), .if_id_flush_o(iffl_b), .id_ex_en_o(idexen_b),
    .id_ex_flush_o(idexfl_b), .ex_mem_en_o(exm_b), .mem_wb_en_o(mwb_b), .halted_o(halted_b),
    .state_o(st_b), .stall_cnt_o(sc_b), .flush_cnt_o(fc_b));

  // Action vectors: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam bit [6:0] A_ADV = 7'b1101011;
  localparam bit [6:0] A_FRZ = 7'b0000000;
  localparam bit [6:0] A_RED = 7'b1111111;
  localparam bit [6:0] A_LDU = 7'b0001111;
  localparam bit [6:0] A_BUB = 7'b0111011;
  localparam bit [6:0] A_DRN = 7'b0111111;

  typedef struct packed {
    logic [6:0]  en;
    logic [1:0]  st;
    logic        halted;
    logic [31:0] stall;
    logic [31:0] flush;
    logic [3:0]  stall4;
    logic [3:0]  flush4;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passed = 0;

  // Reference model: mode 0 run, 1 waiting on memory, 2 draining, 3 halted
  int m_mode = 0, m_drain = 0, m_stall = 0, m_flush = 0;

  function automatic logic [3:0] sat4(input int v);
    sat4 = (v > 15) ? 4'd15 : v[3:0];
  endfunction

  task automatic push_reset_expect();
    exp_t e;
    e = '0;
    exp_q.push_back(e);
    m_mode = 0; m_drain = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_ni = 1'b0;
    ld = 1'b0; rd = 1'b0; req = 1'b0; ack = 1'b0; iv = 1'b1; hl = 1'b0;
    push_reset_expect();
  endtask

  task automatic step(input bit i_ld, input bit i_rd, input bit i_req,
                      input bit i_ack, input bit i_iv, input bit i_hl);
    exp_t e;
    bit [6:0] v;
    int nmode, nd;
    bit rules, incf, mstall;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    ld = i_ld; rd = i_rd; req = i_req; ack = i_ack; iv = i_iv; hl = i_hl;
    v = A_ADV; nmode = m_mode; nd = m_drain; rules = 0; incf = 0;
    mstall = i_req && !i_ack;
    if (m_mode == 0) begin
      if (mstall) begin v = A_FRZ; nmode = 1; end else rules = 1;
    end else if (m_mode == 1) begin
      if (!i_ack) v = A_FRZ; else begin rules = 1; nmode = 0; end
    end else if (m_mode == 2) begin
      if (mstall) v = A_FRZ;
      else begin
        v = A_DRN;
        if (m_drain == 0) nmode = 3; else nd = m_drain - 1;
      end
    end else begin
      v = A_FRZ;
    end
    if (rules) begin
      if (i_rd) begin v = A_RED; incf = 1; end
      else if (i_ld) v = A_LDU;
      else if (i_hl) begin v = A_BUB; nmode = 2; nd = DRAIN - 1; end
      else if (!i_iv) v = A_BUB;
      else v = A_ADV;
    end
    e.en = v;
    e.st = m_mode[1:0];
    e.halted = (m_mode == 3);
    e.stall = m_stall;
    e.flush = m_flush;
    e.stall4 = sat4(m_stall);
    e.flush4 = sat4(m_flush);
    exp_q.push_back(e);
    if ((m_mode <= 1) && !v[6]) m_stall++;
    if (incf) m_flush++;
    m_mode = nmode;
    m_drain = nd;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  // Monitor: the DUT presents a control word every cycle; compare mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("enables", {57'd0, pc_a, ifen_a, iffl_a, idexen_a, idexfl_a, exm_a, mwb_a}, {57'd0, e.en});
      check("enables_w4", {57'd0, pc_b, ifen_b, iffl_b, idexen_b, idexfl_b, exm_b, mwb_b}, {57'd0, e.en});
      check("state_halted", {61'd0, st_a, halted_a}, {61'd0, e.st, e.halted});
      check("state_halted_w4", {61'd0, st_b, halted_b}, {61'd0, e.st, e.halted});
      check("counters", {sc_a, fc_a}, {e.stall, e.flush});
      check("counters_w4", {56'd0, sc_b, fc_b}, {56'd0, e.stall4, e.flush4});
    end
  end

  initial begin
    // T1: reset then clean advance
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    // T2: single load-use bubble
    step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // T3: memory access acked after three stalled cycles
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // redirect arriving during a memory stall is honoured on the ack cycle
    step(0, 1, 1, 0, 1, 0);
    step(0, 1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    // T4: redirect beats load-use
    do_reset();
    step(1, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // T5: halt, drain with one memory-stalled cycle, then stuck in HALTED
    do_reset();
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 1);
    // T6: counter saturation, then reset from MEM_WAIT
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    do_reset();
    step(0, 0, 0, 0, 1, 0);
    // halt accepted on the ack cycle out of MEM_WAIT
    step(0, 0, 1, 0, 1, 1);
    step(0, 0, 1, 1, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    // Randomized episodes
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        step($urandom_range(99) < 15, $urandom_range(99) < 15, $urandom_range(99) < 30,
             $urandom_range(99) < 50, $urandom_range(99) < 85, $urandom_range(99) < 3);
      end
    end
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
